// File: rtl/ifu_ibuf.sv
// -----------------------------------------------------------------------------
// ifu_ibuf : instruction buffer at the tail of the IFU
//
// Purpose:
//   Takes 4-slot fetch packets (128 bits) with a per-slot valid mask. Set slots
//   are packed, with the holes removed, into a circular queue of 32-bit
//   instructions. The four oldest instructions are presented in program order on
//   lanes A..D toward decode. A flush discards everything that is buffered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               redirect; empties the queue, blocks enq/deq this cycle
//   fetch_valid/_ready  fetch packet handshake (ready = room for a full packet)
//   fetch_mask[3:0]     slot valid bits, bit k -> fetch_data[32k+31:32k]
//   fetch_data[127:0]   four instructions, slot 0 oldest
//   ifu_instX_valid     lane X (A oldest .. D youngest) holds an instruction
//   ifu_instX_allowIn   decode accepts lane X
//   ifu_instX_data      lane X instruction (0 while not valid)
// -----------------------------------------------------------------------------
module ifu_ibuf #(
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         fetch_valid,
   output logic         fetch_ready,
   input  logic [3:0]   fetch_mask,
   input  logic [127:0] fetch_data,
   output logic         ifu_instA_valid,
   input  logic         ifu_instA_allowIn,
   output logic [31:0]  ifu_instA_data,
   output logic         ifu_instB_valid,
   input  logic         ifu_instB_allowIn,
   output logic [31:0]  ifu_instB_data,
   output logic         ifu_instC_valid,
   input  logic         ifu_instC_allowIn,
   output logic [31:0]  ifu_instC_data,
   output logic         ifu_instD_valid,
   input  logic         ifu_instD_allowIn,
   output logic [31:0]  ifu_instD_data
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [31:0]  storage_q [DEPTH];
   logic [PW:0]  head_q, head_d;
   logic [PW:0]  tail_q, tail_d;
   logic [PW:0]  count_q, count_d;

   logic [PW:0]  free_slots;
   logic         enq_fire;
   logic [2:0]   slot_off [4];
   logic [2:0]   enq_n;
   logic [2:0]   deq_n;
   logic [3:0]   lane_vld;
   logic [3:0]   lane_allow;
   logic [3:0]   lane_fire;
   logic [31:0]  lane_dat [4];
   logic [PW-1:0] lane_idx [4];

   assign free_slots  = (PW+1)'(DEPTH) - count_q;
   assign fetch_ready = !rst && !flush && (free_slots >= (PW+1)'(4));
   assign enq_fire    = fetch_valid && fetch_ready;

   assign lane_allow = {ifu_instD_allowIn, ifu_instC_allowIn,
                        ifu_instB_allowIn, ifu_instA_allowIn};

   // Compaction: each set slot lands at tail + (number of set slots below it).
   always_comb begin
      slot_off[0] = 3'd0;
      for (int k = 1; k < 4; k++) begin
         slot_off[k] = slot_off[k-1] + {2'b00, fetch_mask[k-1]};
      end
      enq_n = enq_fire ? (slot_off[3] + {2'b00, fetch_mask[3]}) : 3'd0;
   end

   // Lanes read registered state only; a lane fires only behind a firing
   // older lane, so deq_n is always a contiguous prefix count.
   always_comb begin
      deq_n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         lane_idx[k] = head_q[PW-1:0] + PW'(k);
         lane_vld[k] = !rst && !flush && (count_q > (PW+1)'(k));
         lane_dat[k] = lane_vld[k] ? storage_q[lane_idx[k]] : 32'd0;
         if (k == 0) begin
            lane_fire[k] = lane_vld[k] && lane_allow[k];
         end else begin
            lane_fire[k] = lane_vld[k] && lane_allow[k] && lane_fire[k-1];
         end
         deq_n = deq_n + {2'b00, lane_fire[k]};
      end
   end

   assign ifu_instA_valid = lane_vld[0];
   assign ifu_instB_valid = lane_vld[1];
   assign ifu_instC_valid = lane_vld[2];
   assign ifu_instD_valid = lane_vld[3];
   assign ifu_instA_data  = lane_dat[0];
   assign ifu_instB_data  = lane_dat[1];
   assign ifu_instC_data  = lane_dat[2];
   assign ifu_instD_data  = lane_dat[3];

   always_comb begin
      head_d  = head_q + {{(PW-2){1'b0}}, deq_n};
      tail_d  = tail_q + {{(PW-2){1'b0}}, enq_n};
      count_d = count_q + {{(PW-2){1'b0}}, enq_n} - {{(PW-2){1'b0}}, deq_n};
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is data only and is never reset. With >= 4 free slots guaranteed
   // by fetch_ready, written entries never alias the ones being read.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         for (int k = 0; k < 4; k++) begin
            if (fetch_mask[k]) begin
               storage_q[tail_q[PW-1:0] + PW'(slot_off[k])] <= fetch_data[32*k +: 32];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count_q <= (PW+1)'(DEPTH));
         assert ((tail_q - head_q) == count_q);
         assert ({{(PW-2){1'b0}}, deq_n} <= count_q);
      end
   end

endmodule
